// File: rtl/mc_ctl.sv
// Multi-cycle control FSM for the MIPS-subset datapath (FETCH/DECODE/EXEC/MEM/WB).
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unknown instructions into HALT.
module mc_ctl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IrWrite,
  output logic       PcWrite,
  output logic [1:0] PcSrc,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WdSel,
  output logic       AluSrc,
  output logic [3:0] ExtOp,
  output logic [3:0] AluOp,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_rtype, w_addu, w_subu, w_jr, w_jalr;
  logic w_ori, w_lui, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_known;

  logic       w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write;
  logic [1:0] w_pc_src, w_reg_dst, w_wd_sel;
  logic       w_reg_write, w_alu_src, w_instr_done, w_illegal;
  logic [3:0] w_ext_op, w_alu_op;

  assign w_rtype = (opcode == 6'b000000);
  assign w_addu  = w_rtype && (func == 6'b100001);
  assign w_subu  = w_rtype && (func == 6'b100011);
  assign w_jr    = w_rtype && (func == 6'b001000);
  assign w_jalr  = w_rtype && (func == 6'b001001);
  assign w_ori   = (opcode == 6'b001101);
  assign w_lui   = (opcode == 6'b001111);
  assign w_lw    = (opcode == 6'b100011);
  assign w_sw    = (opcode == 6'b101011);
  assign w_beq   = (opcode == 6'b000100);
  assign w_bne   = (opcode == 6'b000101);
  assign w_j     = (opcode == 6'b000010);
  assign w_jal   = (opcode == 6'b000011);
  assign w_known = w_addu | w_subu | w_jr | w_jalr | w_ori | w_lui |
                   w_lw | w_sw | w_beq | w_bne | w_j | w_jal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'b00;
    w_reg_write  = 1'b0;
    w_reg_dst    = 2'b00;
    w_wd_sel     = 2'b00;
    w_alu_src    = 1'b0;
    w_ext_op     = 4'b0000;
    w_alu_op     = 4'b0000;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;

    // ALU controls follow the decode in every state; only EXEC consumes them
    if (w_ori) begin
      w_alu_src = 1'b1;
      w_alu_op  = 4'b0010;
    end else if (w_lui) begin
      w_alu_src = 1'b1;
      w_ext_op  = 4'b0010;
    end else if (w_lw || w_sw) begin
      w_alu_src = 1'b1;
      w_ext_op  = 4'b0001;
    end else if (w_subu || w_beq || w_bne) begin
      w_alu_op  = 4'b0001;
    end

    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_j || w_jal || w_jr || w_jalr) begin
          w_pc_write   = 1'b1;
          w_pc_src     = (w_jr || w_jalr) ? 2'b11 : 2'b10;
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
          if (w_jal || w_jalr) begin
            w_reg_write = 1'b1;
            w_reg_dst   = w_jal ? 2'b10 : 2'b01;
            w_wd_sel    = 2'b10;
          end
        end else if (w_known) begin
          w_next = S_EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (w_beq || w_bne) begin
          w_pc_write   = w_beq ? zero : !zero;
          w_pc_src     = 2'b01;
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        // Request, address select and write strobe stay put until the ready cycle
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = w_sw;
        if (mem_ready) begin
          if (w_sw) begin
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
        if (w_addu || w_subu) w_reg_dst = 2'b01;
        else if (w_lw)        w_wd_sel  = 2'b01;
      end
      S_HALT: begin
        w_alu_src = 1'b0;
        w_ext_op  = 4'b0000;
        w_alu_op  = 4'b0000;
`ifdef MC_ILLEGAL_TRAP_EN
        w_illegal = 1'b1;
        w_next    = S_HALT;
`else
        w_next    = S_FETCH;
`endif
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset gates every strobe combinationally so a pending request dies immediately
  assign mem_req    = rst_n & w_mem_req;
  assign mem_we     = rst_n & w_mem_we;
  assign IorD       = rst_n & w_iord;
  assign IrWrite    = rst_n & w_ir_write;
  assign PcWrite    = rst_n & w_pc_write;
  assign PcSrc      = rst_n ? w_pc_src  : 2'b00;
  assign RegWrite   = rst_n & w_reg_write;
  assign RegDst     = rst_n ? w_reg_dst : 2'b00;
  assign WdSel      = rst_n ? w_wd_sel  : 2'b00;
  assign AluSrc     = rst_n & w_alu_src;
  assign ExtOp      = rst_n ? w_ext_op  : 4'b0000;
  assign AluOp      = rst_n ? w_alu_op  : 4'b0000;
  assign instr_done = rst_n & w_instr_done;
  assign illegal    = rst_n & w_illegal;
  assign state      = rst_n ? 3'(r_state) : 3'd0;

endmodule

// File: tb/tb_mc_ctl.sv
// Directed, table-driven bench for mc_ctl plus cycles-per-instruction sequences.
module tb_mc_ctl;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_JALR = 6'b001001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0, func = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, IorD, IrWrite, PcWrite, RegWrite, AluSrc, instr_done, illegal;
  logic [1:0] PcSrc, RegDst, WdSel;
  logic [3:0] ExtOp, AluOp;
  logic [2:0] state;

  mc_ctl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IrWrite(IrWrite), .PcWrite(PcWrite), .PcSrc(PcSrc), .RegWrite(RegWrite),
    .RegDst(RegDst), .WdSel(WdSel), .AluSrc(AluSrc), .ExtOp(ExtOp), .AluOp(AluOp),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // {state, mem_req, mem_we, IorD, IrWrite, PcWrite, PcSrc, RegWrite, RegDst, WdSel, AluSrc, ExtOp, AluOp, instr_done, illegal}
  logic [25:0] act;
  assign act = {state, mem_req, mem_we, IorD, IrWrite, PcWrite, PcSrc, RegWrite,
                RegDst, WdSel, AluSrc, ExtOp, AluOp, instr_done, illegal};

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [25:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         waits;
    int         cyc;
  } cpi_t;

  vec_t vecs[$];
  cpi_t cpis[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [25:0] ev(
    input logic [2:0] st, input logic req, input logic we, input logic iord,
    input logic irw, input logic pcw, input logic [1:0] pcs, input logic rw,
    input logic [1:0] rd, input logic [1:0] wd, input logic as,
    input logic [3:0] ext, input logic [3:0] aop, input logic done, input logic ill);
    return {st, req, we, iord, irw, pcw, pcs, rw, rd, wd, as, ext, aop, done, ill};
  endfunction

  task automatic add(input string nm, input logic rst, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic rdy,
                     input logic [25:0] exp);
    vec_t v;
    v.name = nm; v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic add_cpi(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input int waits, input int cyc);
    cpi_t c;
    c.name = nm; c.op = op; c.fn = fn; c.waits = waits; c.cyc = cyc;
    cpis.push_back(c);
  endtask

  // Drives a memory with a fixed number of wait cycles per access and counts cycles to instr_done
  task automatic run_cpi(input cpi_t c);
    int  cyc = 0;
    int  wc = 0;
    bit  done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      opcode = c.op; func = c.fn; zero = 1'b1; mem_ready = 1'b0;
      #1;
      if (mem_req) mem_ready = (wc >= c.waits);
      #1;
      cyc++;
      if (mem_req) wc = mem_ready ? 0 : wc + 1;
      if (instr_done) done = 1;
    end
    n_checks++;
    if (!done || cyc != c.cyc) begin
      n_fail++;
      $display("FAIL cpi_%s: got %0d cycles (done=%0d), expected %0d", c.name, cyc, done, c.cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    add("rst_a", 0, OP_R, F_ADDU, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("rst_b", 0, OP_LW, 0,     0, 1, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("addu_f", 1, OP_R, F_ADDU, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("addu_d", 1, OP_R, F_ADDU, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("addu_e", 1, OP_R, F_ADDU, 0, 1, ev(2,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("addu_w", 1, OP_R, F_ADDU, 0, 1, ev(4,0,0,0,0,0,0,1,1,0,0,0,0,1,0));
    add("subu_f", 1, OP_R, F_SUBU, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,0,0,1,0,0));
    add("subu_d", 1, OP_R, F_SUBU, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0,1,0,0));
    add("subu_e", 1, OP_R, F_SUBU, 0, 1, ev(2,0,0,0,0,0,0,0,0,0,0,0,1,0,0));
    add("subu_w", 1, OP_R, F_SUBU, 0, 1, ev(4,0,0,0,0,0,0,1,1,0,0,0,1,1,0));
    add("lw_fwait", 1, OP_LW, 0, 0, 0, ev(0,1,0,0,0,0,0,0,0,0,1,1,0,0,0));
    add("lw_f",     1, OP_LW, 0, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,1,1,0,0,0));
    add("lw_d",     1, OP_LW, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,1,1,0,0,0));
    add("lw_e",     1, OP_LW, 0, 0, 1, ev(2,0,0,0,0,0,0,0,0,0,1,1,0,0,0));
    for (int i = 0; i < 3; i++)
      add("lw_mwait", 1, OP_LW, 0, 0, 0, ev(3,1,0,1,0,0,0,0,0,0,1,1,0,0,0));
    add("lw_m",     1, OP_LW, 0, 0, 1, ev(3,1,0,1,0,0,0,0,0,0,1,1,0,0,0));
    add("lw_w",     1, OP_LW, 0, 0, 1, ev(4,0,0,0,0,0,0,1,0,1,1,1,0,1,0));
    for (int k = 0; k < 4; k++) begin
      logic [5:0] bop;
      logic       bz, take;
      bop  = (k < 2) ? OP_BEQ : OP_BNE;
      bz   = k[0];
      take = (k < 2) ? bz : !bz;
      add("br_f", 1, bop, 0, bz, 1, ev(0,1,0,0,1,1,0,0,0,0,0,0,1,0,0));
      add("br_d", 1, bop, 0, bz, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0,1,0,0));
      add("br_e", 1, bop, 0, bz, 1, ev(2,0,0,0,0,take,1,0,0,0,0,0,1,1,0));
    end
    add("ori_f", 1, OP_ORI, 0, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,1,0,2,0,0));
    add("ori_d", 1, OP_ORI, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,1,0,2,0,0));
    add("ori_e", 1, OP_ORI, 0, 0, 1, ev(2,0,0,0,0,0,0,0,0,0,1,0,2,0,0));
    add("ori_w", 1, OP_ORI, 0, 0, 1, ev(4,0,0,0,0,0,0,1,0,0,1,0,2,1,0));
    add("lui_f", 1, OP_LUI, 0, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,1,2,0,0,0));
    add("lui_d", 1, OP_LUI, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,1,2,0,0,0));
    add("lui_e", 1, OP_LUI, 0, 0, 1, ev(2,0,0,0,0,0,0,0,0,0,1,2,0,0,0));
    add("lui_w", 1, OP_LUI, 0, 0, 1, ev(4,0,0,0,0,0,0,1,0,0,1,2,0,1,0));
    add("sw_f", 1, OP_SW, 0, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,1,1,0,0,0));
    add("sw_d", 1, OP_SW, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,1,1,0,0,0));
    add("sw_e", 1, OP_SW, 0, 0, 1, ev(2,0,0,0,0,0,0,0,0,0,1,1,0,0,0));
    add("sw_m", 1, OP_SW, 0, 0, 1, ev(3,1,1,1,0,0,0,0,0,0,1,1,0,1,0));
    add("j_f",    1, OP_J,   0,      0, 1, ev(0,1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("j_d",    1, OP_J,   0,      0, 1, ev(1,0,0,0,0,1,2,0,0,0,0,0,0,1,0));
    add("jal_f",  1, OP_JAL, 0,      0, 1, ev(0,1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("jal_d",  1, OP_JAL, 0,      0, 1, ev(1,0,0,0,0,1,2,1,2,2,0,0,0,1,0));
    add("jr_f",   1, OP_R,   F_JR,   0, 1, ev(0,1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("jr_d",   1, OP_R,   F_JR,   0, 1, ev(1,0,0,0,0,1,3,0,0,0,0,0,0,1,0));
    add("jalr_f", 1, OP_R,   F_JALR, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("jalr_d", 1, OP_R,   F_JALR, 0, 1, ev(1,0,0,0,0,1,3,1,1,2,0,0,0,1,0));
    add("swr_f",    1, OP_SW, 0, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,1,1,0,0,0));
    add("swr_d",    1, OP_SW, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,1,1,0,0,0));
    add("swr_e",    1, OP_SW, 0, 0, 1, ev(2,0,0,0,0,0,0,0,0,0,1,1,0,0,0));
    add("swr_mwait",1, OP_SW, 0, 0, 0, ev(3,1,1,1,0,0,0,0,0,0,1,1,0,0,0));
    add("swr_rst",  0, OP_SW, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("swr_rst2", 0, OP_SW, 0, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("swr_rel",  1, OP_SW, 0, 0, 0, ev(0,1,0,0,0,0,0,0,0,0,1,1,0,0,0));
    add("bad_f",    1, OP_BAD, 0, 0, 1, ev(0,1,0,0,1,1,0,0,0,0,0,0,0,0,0));
`ifdef MC_ILLEGAL_TRAP_EN
    add("bad_d",    1, OP_BAD, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 10; i++)
      add("bad_halt", 1, OP_BAD, 0, 0, 1, ev(5,0,0,0,0,0,0,0,0,0,0,0,0,0,1));
`else
    add("bad_d",    1, OP_BAD, 0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,1,0));
    add("bad_next", 1, OP_BAD, 0, 0, 0, ev(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0));
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst; opcode = vecs[i].op; func = vecs[i].fn;
      zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      n_checks++;
      if (act !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL %s [vec %0d]: got %h expected %h", vecs[i].name, i, act, vecs[i].exp);
      end
    end

    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    add_cpi("addu", OP_R,   F_ADDU, 0, 4);
    add_cpi("subu", OP_R,   F_SUBU, 0, 4);
    add_cpi("ori",  OP_ORI, 0,      0, 4);
    add_cpi("lui",  OP_LUI, 0,      0, 4);
    add_cpi("sw",   OP_SW,  0,      0, 4);
    add_cpi("lw",   OP_LW,  0,      0, 5);
    add_cpi("beq",  OP_BEQ, 0,      0, 3);
    add_cpi("bne",  OP_BNE, 0,      0, 3);
    add_cpi("j",    OP_J,   0,      0, 2);
    add_cpi("jal",  OP_JAL, 0,      0, 2);
    add_cpi("jr",   OP_R,   F_JR,   0, 2);
    add_cpi("jalr", OP_R,   F_JALR, 0, 2);
    add_cpi("lw_w2",   OP_LW, 0,      2, 9);
    add_cpi("addu_w1", OP_R,  F_ADDU, 1, 5);
    add_cpi("sw_w3",   OP_SW, 0,      3, 10);
    add_cpi("addu_b",  OP_R,  F_ADDU, 0, 4);
    foreach (cpis[i]) run_cpi(cpis[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
